piece_action_scheduler: RTL

- Owns the falling-piece state (origin row/col/orientation) and sequences its life cycle: spawn, gravity fall, player actions, lock delay, lock, game over.
- Arbitrates player action requests and gravity ticks so that at most one ActionStateUpdate result is committed per cycle.
- Sits between the synchronized key inputs and the ActionStateUpdate/FallingTetrominoRender pair, replacing ad-hoc origin registers.

---
 rtl/piece_action_scheduler_pkg.sv | 35 +++
 rtl/piece_action_scheduler_action_arm.sv | 48 ++++
 rtl/piece_action_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/piece_action_scheduler_pkg.sv
// Shared types and constants for the falling-piece action scheduler.
package piece_action_scheduler_pkg;

    localparam int NUM_ACTIONS = 6;
    localparam logic [3:0] MAX_LOCK_RESETS = 4'd15;

    typedef logic [1:0] orientation_t;

    typedef struct packed {
        logic [4:0]   row;
        logic [4:0]   col;
        orientation_t orientation;
    } piece_pos_t;

    // Index order doubles as arbitration priority (lowest index wins).
    typedef enum logic [2:0] {
        ACT_HARD   = 3'd0,
        ACT_SOFT   = 3'd1,
        ACT_ROT_R  = 3'd2,
        ACT_ROT_L  = 3'd3,
        ACT_MOVE_R = 3'd4,
        ACT_MOVE_L = 3'd5
    } action_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SPAWN      = 3'd1,
        ST_CHECK      = 3'd2,
        ST_FALL       = 3'd3,
        ST_LOCK_DELAY = 3'd4,
        ST_LOCK       = 3'd5,
        ST_GAME_OVER  = 3'd6
    } sched_state_t;

endpackage

// File: rtl/piece_action_scheduler_action_arm.sv
// One player action: rising-edge detect, repeat cooldown and the pending request bit.
module piece_action_scheduler_action_arm #(
    parameter int REPEAT_CYCLES = 8_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic enable,
    input  logic commit,
    output logic pending
);
    localparam int CW = $clog2(REPEAT_CYCLES + 1);

    logic          req_q;
    logic [CW-1:0] cooldown;
    logic          arm;

    assign arm = enable && req && !req_q && (cooldown == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q    <= 1'b0;
            cooldown <= '0;
            pending  <= 1'b0;
        end else begin
            req_q <= req;

            if (arm) begin
                cooldown <= CW'(1);
            end else if (cooldown == CW'(REPEAT_CYCLES)) begin
                cooldown <= '0;
            end else if (cooldown != '0) begin
                cooldown <= cooldown + CW'(1);
            end

            // A fresh press outranks the commit of an older one.
            if (!enable) begin
                pending <= 1'b0;
            end else if (arm) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/piece_action_scheduler.sv
// Owns the falling-piece origin and sequences spawn, gravity, player actions, lock delay and game over.
// Optional macro LOCK_MOVE_RESET_EN: position-changing moves/rotations in lock delay restart the lock timer.
module piece_action_scheduler
    import piece_action_scheduler_pkg::*;
#(
    parameter int GRAVITY_CYCLES = 25_000_000,
    parameter int LOCK_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES  = 8_000_000,
    parameter int SPAWN_ROW      = 0,
    parameter int SPAWN_COL      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_ACTIONS-1:0] req,
    input  piece_pos_t             cand_pos [NUM_ACTIONS],
    input  logic                   spawn_blocked,
    output piece_pos_t             pos,
    output logic                   piece_active,
    output logic [NUM_ACTIONS-1:0] action_taken,
    output logic                   spawn_pulse,
    output logic                   lock_pulse,
    output logic                   game_over
);
    localparam int GW = $clog2(GRAVITY_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam piece_pos_t SPAWN_POS = '{row: 5'(SPAWN_ROW), col: 5'(SPAWN_COL), orientation: 2'd0};

    sched_state_t           state, state_next;
    logic [GW-1:0]          grav_cnt;
    logic                   gravity_pending;
    logic [LW-1:0]          lock_cnt;
    logic [NUM_ACTIONS-1:0] pending, act_req, grant, arm_clear;
    logic                   in_play, arm_enable, landed, grav_wrap, move_reset;
    piece_pos_t             commit_pos;
`ifdef LOCK_MOVE_RESET_EN
    logic [3:0]             reset_count;
`endif

    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_arm
        piece_action_scheduler_action_arm #(
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_arm (
            .clk    (clk),
            .reset  (reset),
            .req    (req[a]),
            .enable (arm_enable),
            .commit (arm_clear[a]),
            .pending(pending[a])
        );
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        act_req    = '0;
        grant      = '0;
        commit_pos = pos;
        state_next = state;
        move_reset = 1'b0;
        in_play    = (state == ST_FALL) || (state == ST_LOCK_DELAY);
        arm_enable = in_play || (state == ST_CHECK);
        landed     = (cand_pos[ACT_SOFT].row == pos.row);
        grav_wrap  = (state == ST_FALL) && (grav_cnt == GW'(GRAVITY_CYCLES - 1));

        if (in_play) begin
            act_req           = pending;
            act_req[ACT_SOFT] = (state == ST_FALL) &&
                                (pending[ACT_SOFT] || gravity_pending || grav_wrap);
        end

        for (int i = 0; i < NUM_ACTIONS; i++) begin
            if (act_req[i] && (grant == '0)) begin
                grant[i]   = 1'b1;
                commit_pos = cand_pos[i];
            end
        end

        // Soft drops make no sense once landed; they are dropped rather than queued.
        arm_clear = grant;
        if (state == ST_LOCK_DELAY) begin
            arm_clear[ACT_SOFT] = 1'b1;
        end

`ifdef LOCK_MOVE_RESET_EN
        move_reset = (state == ST_LOCK_DELAY) && (|grant[5:2]) &&
                     (commit_pos != pos) && (reset_count != MAX_LOCK_RESETS);
`endif

        unique case (state)
            ST_IDLE:       if (start) state_next = ST_SPAWN;
            ST_SPAWN:      state_next = ST_CHECK;
            ST_CHECK:      state_next = spawn_blocked ? ST_GAME_OVER : ST_FALL;
            ST_FALL: begin
                if (grant[ACT_HARD])  state_next = ST_LOCK;
                else if (landed)      state_next = ST_LOCK_DELAY;
            end
            ST_LOCK_DELAY: begin
                if (grant[ACT_HARD])  state_next = ST_LOCK;
                else if ((lock_cnt == LW'(LOCK_CYCLES - 1)) && !move_reset)
                                      state_next = ST_LOCK;
                else if (!landed)     state_next = ST_FALL;
            end
            ST_LOCK:       state_next = ST_SPAWN;
            ST_GAME_OVER:  if (start) state_next = ST_SPAWN;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            pos             <= SPAWN_POS;
            action_taken    <= '0;
            grav_cnt        <= '0;
            gravity_pending <= 1'b0;
            lock_cnt        <= '0;
        end else begin
            state        <= state_next;
            action_taken <= grant;
            pos          <= (state == ST_SPAWN) ? SPAWN_POS : commit_pos;

            if (state == ST_SPAWN) begin
                grav_cnt        <= '0;
                gravity_pending <= 1'b0;
            end else if (state == ST_FALL) begin
                if (grant[ACT_SOFT]) begin
                    grav_cnt        <= '0;
                    gravity_pending <= 1'b0;
                end else if (grav_wrap) begin
                    grav_cnt        <= '0;
                    gravity_pending <= 1'b1;
                end else begin
                    grav_cnt <= grav_cnt + GW'(1);
                end
            end else begin
                gravity_pending <= 1'b0;
            end

            if ((state == ST_LOCK_DELAY) && !move_reset) begin
                lock_cnt <= lock_cnt + LW'(1);
            end else begin
                lock_cnt <= '0;
            end
        end
    end

`ifdef LOCK_MOVE_RESET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_count <= '0;
        end else if (state == ST_SPAWN) begin
            reset_count <= '0;
        end else if (move_reset) begin
            reset_count <= reset_count + 4'd1;
        end
    end
`endif

    assign piece_active = in_play;
    assign spawn_pulse  = (state == ST_SPAWN);
    assign lock_pulse   = (state == ST_LOCK);
    assign game_over    = (state == ST_GAME_OVER);

endmodule
